// File: rtl/estimate_seq_if.sv
// rtl/estimate_seq_if.sv - host/array signal bundle for the estimate array sequencer
interface estimate_seq_if #(
    parameter int ADDR_W = 16,
    parameter int CNT_W  = 16
);
    logic              start;
    logic              cfg_mode8;
    logic [ADDR_W-1:0] cfg_base;
    logic [CNT_W-1:0]  cfg_nacc;
    logic [CNT_W-1:0]  cfg_npool;
    logic [CNT_W-1:0]  cfg_ngrp;
    logic              in_valid;
    logic [31:0]       in_data;
    logic              in_ready;
    logic [2:0]        com;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
    logic [31:0]       activ;
    logic              out_valid;
    logic [31:0]       out_data;
    logic              out_ready;
    logic              busy;
    logic              done;

    modport master (
        input  start, cfg_mode8, cfg_base, cfg_nacc, cfg_npool, cfg_ngrp,
        input  in_valid, in_data, activ, out_ready,
        output in_ready, com, addr, data, out_valid, out_data, busy, done
    );

    modport slave (
        output start, cfg_mode8, cfg_base, cfg_nacc, cfg_npool, cfg_ngrp,
        output in_valid, in_data, activ, out_ready,
        input  in_ready, com, addr, data, out_valid, out_data, busy, done
    );
endinterface

// File: rtl/estimate_seq.sv
// rtl/estimate_seq.sv - command sequencer driving the 32-lane estimate array
module estimate_seq #(
    parameter int ADDR_W    = 16,
    parameter int CNT_W     = 16,
    parameter int ACTIV_LAT = 3
) (
    input  logic           clk,
    input  logic           reset,
    estimate_seq_if.master bus
);
    localparam int WCNT_W = (ACTIV_LAT > 1) ? $clog2(ACTIV_LAT) : 1;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_INI  = 3'd1;
    localparam logic [2:0] S_ACC  = 3'd2;
    localparam logic [2:0] S_POOL = 3'd3;
    localparam logic [2:0] S_NORM = 3'd4;
    localparam logic [2:0] S_ACTV = 3'd5;
    localparam logic [2:0] S_WAIT = 3'd6;
    localparam logic [2:0] S_OUT  = 3'd7;

    localparam logic [2:0] CMD_INI   = 3'd0;
    localparam logic [2:0] CMD_ACC   = 3'd1;
    localparam logic [2:0] CMD_POOL  = 3'd2;
    localparam logic [2:0] CMD_NORM  = 3'd3;
    localparam logic [2:0] CMD_ACTIV = 3'd4;
    localparam logic [2:0] CMD_ACC8  = 3'd5;
    localparam logic [2:0] CMD_NORM8 = 3'd6;
    localparam logic [2:0] CMD_NOP   = 3'd7;

    logic [2:0]        state_q, state_d;
    logic              mode8_q, mode8_d;
    logic [CNT_W-1:0]  nacc_q, nacc_d;
    logic [CNT_W-1:0]  npool_q, npool_d;
    logic [CNT_W-1:0]  ngrp_q, ngrp_d;
    logic [ADDR_W-1:0] gbase_q, gbase_d;
    logic [CNT_W-1:0]  k_q, k_d;
    logic [CNT_W-1:0]  win_q, win_d;
    logic [CNT_W-1:0]  grp_q, grp_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic [2:0]        com_q, com_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       data_q, data_d;
    logic              out_valid_q, out_valid_d;
    logic [31:0]       out_data_q, out_data_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [CNT_W-1:0]  k_inc, win_inc, grp_inc;
    logic              cfg_zero;

    // k never exceeds nacc, so the max-count case cannot wrap before the compare
    assign k_inc    = k_q + CNT_W'(1);
    assign win_inc  = win_q + CNT_W'(1);
    assign grp_inc  = grp_q + CNT_W'(1);
    assign cfg_zero = (bus.cfg_nacc == '0) || (bus.cfg_npool == '0) || (bus.cfg_ngrp == '0);

    always_comb begin
        state_d     = state_q;
        mode8_d     = mode8_q;
        nacc_d      = nacc_q;
        npool_d     = npool_q;
        ngrp_d      = ngrp_q;
        gbase_d     = gbase_q;
        k_d         = k_q;
        win_d       = win_q;
        grp_d       = grp_q;
        wcnt_d      = wcnt_q;
        com_d       = CMD_NOP;
        addr_d      = addr_q;
        data_d      = data_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    if (cfg_zero) begin
                        done_d = 1'b1;
                    end else begin
                        mode8_d = bus.cfg_mode8;
                        nacc_d  = bus.cfg_nacc;
                        npool_d = bus.cfg_npool;
                        ngrp_d  = bus.cfg_ngrp;
                        gbase_d = bus.cfg_base;
                        grp_d   = '0;
                        busy_d  = 1'b1;
                        state_d = S_INI;
                    end
                end
            end
            S_INI: begin
                com_d   = CMD_INI;
                addr_d  = gbase_q;
                data_d  = '0;
                k_d     = '0;
                win_d   = '0;
                state_d = S_ACC;
            end
            S_ACC: begin
                if (bus.in_valid) begin
                    com_d  = mode8_q ? CMD_ACC8 : CMD_ACC;
                    addr_d = gbase_q + ADDR_W'(k_q);
                    data_d = bus.in_data;
                    k_d    = k_inc;
                    if (k_inc == nacc_q) state_d = S_POOL;
                end
            end
            S_POOL: begin
                com_d   = CMD_POOL;
                addr_d  = gbase_q;
                data_d  = '0;
                k_d     = '0;
                win_d   = win_inc;
                state_d = (win_inc == npool_q) ? S_NORM : S_ACC;
            end
            S_NORM: begin
                com_d   = mode8_q ? CMD_NORM8 : CMD_NORM;
                addr_d  = gbase_q + ADDR_W'(nacc_q);
                state_d = S_ACTV;
            end
            S_ACTV: begin
                com_d   = CMD_ACTIV;
                wcnt_d  = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // activ is sampled on the last wait cycle so out_valid lands ACTIV_LAT after ACTIV
                if (wcnt_q == WCNT_W'(ACTIV_LAT - 1)) begin
                    out_data_d  = bus.activ;
                    out_valid_d = 1'b1;
                    state_d     = S_OUT;
                end else begin
                    wcnt_d = wcnt_q + WCNT_W'(1);
                end
            end
            S_OUT: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    gbase_d     = gbase_q + ADDR_W'(nacc_q) + ADDR_W'(1);
                    grp_d       = grp_inc;
                    if (grp_inc == ngrp_q) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_INI;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            mode8_q     <= 1'b0;
            nacc_q      <= '0;
            npool_q     <= '0;
            ngrp_q      <= '0;
            gbase_q     <= '0;
            k_q         <= '0;
            win_q       <= '0;
            grp_q       <= '0;
            wcnt_q      <= '0;
            com_q       <= CMD_NOP;
            addr_q      <= '0;
            data_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode8_q     <= mode8_d;
            nacc_q      <= nacc_d;
            npool_q     <= npool_d;
            ngrp_q      <= ngrp_d;
            gbase_q     <= gbase_d;
            k_q         <= k_d;
            win_q       <= win_d;
            grp_q       <= grp_d;
            wcnt_q      <= wcnt_d;
            com_q       <= com_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus.in_ready  = (state_q == S_ACC);
    assign bus.com       = com_q;
    assign bus.addr      = addr_q;
    assign bus.data      = data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_estimate_seq.sv
// tb/tb_estimate_seq.sv - scoreboard bench for estimate_seq
module tb_estimate_seq;
    localparam logic [2:0] NOP = 3'd7;
    typedef struct packed {
        logic [2:0]  com;
        logic [15:0] addr;
        logic [31:0] data;
    } cmd_t;

    logic clk = 1'b0;
    logic reset;
    estimate_seq_if sif ();
    estimate_seq dut (.clk(clk), .reset(reset), .bus(sif));
    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    cmd_t        exp_cmd[$];
    logic [31:0] exp_out[$];
    int word_idx = 0, exp_word = 0, stall_at = -1, stall_cycles = 0;
    bit feed_en = 1'b0, early_ready = 1'b0;
    int ready_hold = 0;
    int cyc = 0, last_activ_cyc = -100, done_cnt = 0, grp_seen = 0, exp_grp = 0;
    logic [15:0] prev_addr = '0;
    logic [31:0] prev_data = '0;
    logic        prev_ov = 1'b0;

    logic [2:0]  t1_com [9] = '{3'd0, 3'd1, 3'd1, 3'd2, 3'd1, 3'd1, 3'd2, 3'd3, 3'd4};
    logic [15:0] t1_addr[9] = '{16'h10, 16'h10, 16'h11, 16'h10, 16'h10, 16'h11, 16'h10, 16'h12, 16'h12};
    int          t1_word[9] = '{-1, 0, 1, -1, 2, 3, -1, -1, -1};

    function automatic logic [31:0] wval(input int i);
        return 32'hA500_0000 + 32'(i);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic push_cmd(input logic [2:0] c, input logic [15:0] a, input logic [31:0] d);
        cmd_t e;
        e.com = c; e.addr = a; e.data = d;
        exp_cmd.push_back(e);
    endtask

    task automatic push_result();
        exp_out.push_back(32'hC0DE_0000 + 32'(exp_grp));
        exp_grp++;
    endtask

    task automatic push_group(input bit m8, input logic [15:0] gb, input int nacc, input int npool);
        push_cmd(3'd0, gb, 32'h0);
        for (int w = 0; w < npool; w++) begin
            for (int k = 0; k < nacc; k++) begin
                push_cmd(m8 ? 3'd5 : 3'd1, gb + 16'(k), wval(exp_word));
                exp_word++;
            end
            push_cmd(3'd2, gb, 32'h0);
        end
        push_cmd(m8 ? 3'd6 : 3'd3, gb + 16'(nacc), 32'h0);
        push_cmd(3'd4, gb + 16'(nacc), 32'h0);
        push_result();
    endtask

    task automatic set_cfg(input bit m8, input logic [15:0] base, input int nacc, input int npool, input int ngrp);
        sif.cfg_mode8 = m8;
        sif.cfg_base  = base;
        sif.cfg_nacc  = 16'(nacc);
        sif.cfg_npool = 16'(npool);
        sif.cfg_ngrp  = 16'(ngrp);
    endtask

    task automatic pulse_start();
        sif.start = 1'b1;
        @(posedge clk); #2;
        sif.start = 1'b0;
    endtask

    task automatic go(input string name, input bit inject);
        int d0;
        bit got;
        d0  = done_cnt;
        got = 1'b0;
        pulse_start();
        check({name, "_busy"}, sif.busy, 1);
        if (inject) begin
            repeat (4) begin @(posedge clk); #2; end
            set_cfg(1'b0, 16'h99, 1, 1, 1);
            pulse_start();
        end
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (done_cnt != d0) begin got = 1'b1; break; end
        end
        check({name, "_done_seen"}, got, 1);
        repeat (4) @(negedge clk);
        check({name, "_done_once"}, done_cnt - d0, 1);
        check({name, "_busy_end"}, sif.busy, 0);
        check({name, "_cmd_left"}, exp_cmd.size(), 0);
        check({name, "_out_left"}, exp_out.size(), 0);
        @(posedge clk); #2;
    endtask

    task automatic check_reset_vals(input string name);
        check({name, "_com"}, sif.com, NOP);
        check({name, "_addr"}, sif.addr, 0);
        check({name, "_data"}, sif.data, 0);
        check({name, "_in_ready"}, sif.in_ready, 0);
        check({name, "_out_valid"}, sif.out_valid, 0);
        check({name, "_out_data"}, sif.out_data, 0);
        check({name, "_busy"}, sif.busy, 0);
        check({name, "_done"}, sif.done, 0);
    endtask

    // input stream: advances to the next word only after an observed handshake
    initial begin
        bit hs;
        int stall_left;
        stall_left   = 0;
        sif.in_valid = 1'b0;
        sif.in_data  = wval(0);
        forever begin
            @(negedge clk);
            hs = sif.in_valid && sif.in_ready && !reset;
            @(posedge clk); #1;
            if (hs) word_idx++;
            if (stall_left > 0) begin
                sif.in_valid = 1'b0;
                stall_left--;
            end else if (hs && word_idx == stall_at) begin
                sif.in_valid = 1'b0;
                stall_left   = 2;
            end else begin
                sif.in_valid = feed_en;
            end
            sif.in_data = wval(word_idx);
        end
    end

    initial begin
        int ov_cnt;
        ov_cnt = 0;
        sif.out_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (sif.out_valid) begin
                ov_cnt++;
                sif.out_ready = (ov_cnt > ready_hold);
            end else begin
                ov_cnt = 0;
                sif.out_ready = early_ready;
            end
        end
    end

    always @(negedge clk) begin
        cmd_t e;
        cyc++;
        if (!reset) begin
            if (sif.com !== NOP) begin
                if (exp_cmd.size() == 0) begin
                    check("unexpected_cmd", sif.com, NOP);
                end else begin
                    e = exp_cmd.pop_front();
                    check("cmd_com", sif.com, e.com);
                    check("cmd_addr", sif.addr, e.addr);
                    check("cmd_data", sif.data, e.data);
                    check("cmd_during_out", sif.out_valid, 0);
                end
                if (sif.com == 3'd4) last_activ_cyc = cyc;
            end else begin
                check("nop_addr_held", sif.addr, prev_addr);
                check("nop_data_held", sif.data, prev_data);
            end
            if (sif.out_valid && !prev_ov) check("activ_latency", 64'(cyc - last_activ_cyc), 3);
            if (sif.out_valid) begin
                if (exp_out.size() == 0) begin
                    check("unexpected_out", sif.out_valid, 0);
                end else begin
                    check("out_data", sif.out_data, exp_out[0]);
                    if (sif.out_ready) begin
                        void'(exp_out.pop_front());
                        grp_seen++;
                    end
                end
            end
            if (sif.done) done_cnt++;
            if (sif.in_ready && !sif.in_valid) stall_cycles++;
        end
        prev_addr = sif.addr;
        prev_data = sif.data;
        prev_ov   = sif.out_valid && !reset;
        sif.activ = sif.out_valid ? 32'hDEAD_BEEF : 32'hC0DE_0000 + 32'(grp_seen);
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, d0;
        bit got;
        reset = 1'b1;
        sif.start = 1'b0;
        set_cfg(1'b0, 16'h0, 0, 0, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_vals("rst");
        @(posedge clk); #2;
        reset = 1'b0;
        repeat (2) begin @(posedge clk); #2; end
        feed_en = 1'b1;

        // binary, hand-written command stream
        early_ready = 1'b1; ready_hold = 0;
        set_cfg(1'b0, 16'h10, 2, 2, 1);
        exp_word = word_idx;
        for (int i = 0; i < 9; i++)
            push_cmd(t1_com[i], t1_addr[i], (t1_word[i] < 0) ? 32'h0 : wval(exp_word + t1_word[i]));
        exp_word += 4;
        push_result();
        go("bin", 1'b0);

        // 8-bit mode, with a start pulse and cfg changes while busy
        set_cfg(1'b1, 16'h10, 2, 2, 1);
        exp_word = word_idx;
        push_group(1'b1, 16'h10, 2, 2);
        go("mode8", 1'b1);

        // in_valid gap of 3 cycles in the middle of ACC
        set_cfg(1'b0, 16'h40, 4, 1, 1);
        exp_word = word_idx;
        stall_at = word_idx + 2;
        s0 = stall_cycles;
        push_group(1'b0, 16'h40, 4, 1);
        go("stall", 1'b0);
        check("stall_cycles", stall_cycles - s0, 3);
        stall_at = -1;

        // two groups with a held-off result handshake
        early_ready = 1'b0; ready_hold = 5;
        set_cfg(1'b0, 16'h20, 3, 1, 2);
        exp_word = word_idx;
        push_group(1'b0, 16'h20, 3, 1);
        push_group(1'b0, 16'h24, 3, 1);
        go("ngrp2", 1'b0);
        early_ready = 1'b1; ready_hold = 0;

        // reset while ACC is in progress
        set_cfg(1'b0, 16'h50, 4, 1, 1);
        exp_word = word_idx;
        push_cmd(3'd0, 16'h50, 32'h0);
        push_cmd(3'd1, 16'h50, wval(exp_word));
        push_cmd(3'd1, 16'h51, wval(exp_word + 1));
        pulse_start();
        got = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk); #1;
            if (exp_cmd.size() == 0) begin got = 1'b1; break; end
        end
        check("rst_mid_reached", got, 1);
        reset = 1'b1;
        #1;
        check_reset_vals("rst_mid");
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
        repeat (8) begin @(posedge clk); #2; end
        exp_word = word_idx;
        push_group(1'b0, 16'h50, 4, 1);
        go("rst_rerun", 1'b0);

        // zero pool count: immediate done, never busy, no commands
        set_cfg(1'b0, 16'h10, 2, 0, 1);
        d0 = done_cnt;
        pulse_start();
        @(negedge clk);
        check("zero_done_hi", sif.done, 1);
        check("zero_busy0", sif.busy, 0);
        @(negedge clk);
        check("zero_done_lo", sif.done, 0);
        check("zero_busy1", sif.busy, 0);
        repeat (4) @(negedge clk);
        check("zero_done_once", done_cnt - d0, 1);
        check("zero_busy_end", sif.busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
